// File: rtl/mod_write_buffer.sv
// Posted-write buffer between the write-through cache and the SRAM data port.
// Stores are accepted in one cycle, drained in order, and forwarded to read misses.
module mod_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int LOG2_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    output logic        full,
    output logic        empty,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_hit,
    output logic [31:0] rd_data,
    output logic        sram_de,
    output logic        sram_drw,
    output logic [31:0] sram_daddr,
    output logic [31:0] sram_din,
    input  logic        sram_rdy,
    output logic [1:0]  dbg_state
);

    // Handshake: a store is taken on any cycle where wr_req && wr_ack; the
    // cache holds wr_req and its payload stable until it sees wr_ack. An SRAM
    // write is offered while sram_de is high and completes on the cycle
    // sram_de && sram_rdy.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH+1)'(DEPTH);

    logic [29:0]           addr_q [DEPTH];
    logic [31:0]           data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [LOG2_DEPTH-1:0] head_q, head_d;
    logic [LOG2_DEPTH-1:0] tail_q, tail_d;
    logic [LOG2_DEPTH:0]   count_q, count_d;

    state_t      state_q, state_d;
    logic        sram_de_q, sram_de_d;
    logic [31:0] sram_daddr_q, sram_daddr_d;
    logic [31:0] sram_din_q, sram_din_d;

    logic                  deq;
    logic                  fwd_hit;
    logic [31:0]           fwd_data;
    logic [LOG2_DEPTH-1:0] fwd_idx;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0]};

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0) && (state_q == S_IDLE);
    // Gated by rst so nothing is acknowledged while reset is held.
    assign wr_ack = wr_req & ~full & rst;
    assign deq    = (state_q == S_WRITE) & sram_rdy;

    assign sram_de    = sram_de_q;
    assign sram_drw   = sram_de_q;
    assign sram_daddr = sram_daddr_q;
    assign sram_din   = sram_din_q;
    assign dbg_state  = state_q;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (wr_ack) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        case ({wr_ack, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        sram_de_d    = sram_de_q;
        sram_daddr_d = sram_daddr_q;
        sram_din_d   = sram_din_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d      = S_WRITE;
                    sram_de_d    = 1'b1;
                    sram_daddr_d = {addr_q[head_q], 2'b00};
                    sram_din_d   = data_q[head_q];
                end
            end
            S_WRITE: begin
                if (sram_rdy) begin
                    state_d   = S_RECOVER;
                    sram_de_d = 1'b0;
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                sram_de_d = 1'b0;
            end
        endcase
    end

    // Walk oldest to youngest so the last match wins; valid entries are
    // contiguous from head, including the one currently being written.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + LOG2_DEPTH'(i);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == rd_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign rd_hit  = fwd_hit & rd_req & rst;
    assign rd_data = rd_hit ? fwd_data : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            sram_de_q    <= 1'b0;
            sram_daddr_q <= 32'd0;
            sram_din_q   <= 32'd0;
        end else begin
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            sram_de_q    <= sram_de_d;
            sram_daddr_q <= sram_daddr_d;
            sram_din_q   <= sram_din_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ack) begin
            addr_q[tail_q] <= wr_addr[31:2];
            data_q[tail_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_mod_write_buffer.sv
// Bench for mod_write_buffer: a queue-based model of the posted writes is
// compared with the DUT every cycle, plus directed scenarios with literal values.
module tb_mod_write_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_req = 1'b0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = 32'd0;
    logic        sram_rdy = 1'b0;
    logic        wr_ack, full, empty, rd_hit, sram_de, sram_drw;
    logic [31:0] rd_data, sram_daddr, sram_din;
    logic [1:0]  dbg_state;

    mod_write_buffer #(.DEPTH(4), .LOG2_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .full(full), .empty(empty),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
        .sram_de(sram_de), .sram_drw(sram_drw), .sram_daddr(sram_daddr),
        .sram_din(sram_din), .sram_rdy(sram_rdy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: m_q holds buffered stores oldest first ({word addr, data});
    // m_stage 0 = no write offered, 1 = write offered, 2 = one dead cycle.
    logic [61:0] m_q[$];
    logic [63:0] exp_q[$];
    int          m_stage = 0;
    logic [31:0] m_daddr = 32'd0;
    logic [31:0] m_din = 32'd0;
    bit          model_valid = 1'b0;
    int          n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic model_step();
        bit enq, deq;
        if (!rst) begin
            m_q.delete();
            exp_q.delete();
            m_stage     = 0;
            m_daddr     = 32'd0;
            m_din       = 32'd0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            enq = wr_req && (m_q.size() < 4);
            deq = (m_stage == 1) && sram_rdy;
            case (m_stage)
                0: if (m_q.size() != 0) begin
                    m_stage = 1;
                    m_daddr = {m_q[0][61:32], 2'b00};
                    m_din   = m_q[0][31:0];
                end
                1: if (sram_rdy) m_stage = 2;
                default: m_stage = 0;
            endcase
            if (deq) void'(m_q.pop_front());
            if (enq) begin
                m_q.push_back({wr_addr[31:2], wr_data});
                exp_q.push_back({wr_addr[31:2], 2'b00, wr_data});
            end
        end
    endtask

    task automatic compare_step();
        logic        h;
        logic [31:0] d;
        logic        f, e;
        logic [63:0] e64;
        f = (m_q.size() == 4);
        e = (m_q.size() == 0) && (m_stage == 0);
        h = 1'b0;
        d = 32'd0;
        foreach (m_q[i]) begin
            if (m_q[i][61:32] == rd_addr[31:2]) begin
                h = 1'b1;
                d = m_q[i][31:0];
            end
        end
        h = h && rd_req && rst;
        if (!h) d = 32'd0;
        chk1("wr_ack", wr_ack, rst && wr_req && !f);
        chk1("full", full, f);
        chk1("empty", empty, e);
        chk1("rd_hit", rd_hit, h);
        chk("rd_data", rd_data, d);
        chk1("sram_de", sram_de, m_stage == 1);
        chk1("sram_drw", sram_drw, m_stage == 1);
        chk("sram_daddr", sram_daddr, m_daddr);
        chk("sram_din", sram_din, m_din);
        if (rst && sram_de && sram_rdy) begin
            n_done++;
            chk1("drain_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e64 = exp_q.pop_front();
                chk("drain_order_addr", sram_daddr, e64[63:32]);
                chk("drain_order_data", sram_din, e64[31:0]);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_valid) compare_step();
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input logic [31:0] a, input logic [31:0] d);
        int n;
        bit got;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            if (wr_ack === 1'b1) got = 1'b1;
            else step();
            n++;
        end
        chk1("post_ack", got, 1'b1);
        step();
        wr_req = 1'b0;
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        while (!(m_q.size() == 0 && m_stage == 0 && !sram_rdy) && n < 500) begin
            step();
            if (sram_rdy) sram_rdy = 1'b0;
            else if (sram_de) sram_rdy = 1'b1;
            n++;
        end
        chk1("drain_all_done", n < 500, 1'b1);
    endtask

    initial begin
        int base, cnt, gap, n;

        // Reset held with a pending store request.
        rst = 1'b0; wr_req = 1'b1; wr_addr = 32'h40; wr_data = 32'h1;
        repeat (3) begin
            step();
            @(negedge clk);
            chk1("t1_wr_ack", wr_ack, 1'b0);
            chk1("t1_empty", empty, 1'b1);
            chk1("t1_sram_de", sram_de, 1'b0);
            chk("t1_sram_daddr", sram_daddr, 32'h0);
        end
        step();
        rst = 1'b1; wr_req = 1'b0;

        // Single store latency.
        wr_req = 1'b1; wr_addr = 32'h104; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        chk1("t2_wr_ack_c0", wr_ack, 1'b1);
        step();
        wr_req = 1'b0;
        @(negedge clk);
        chk1("t2_de_after_e1", sram_de, 1'b0);
        step();
        @(negedge clk);
        chk1("t2_de_after_e2", sram_de, 1'b1);
        chk1("t2_drw", sram_drw, 1'b1);
        chk("t2_daddr", sram_daddr, 32'h104);
        chk("t2_din", sram_din, 32'hDEADBEEF);
        step();
        sram_rdy = 1'b1;
        step();
        sram_rdy = 1'b0;
        @(negedge clk);
        chk1("t2_de_after_rdy", sram_de, 1'b0);
        chk1("t2_empty_recover", empty, 1'b0);
        step();
        @(negedge clk);
        chk1("t2_empty_idle", empty, 1'b1);

        // Fill to full, fifth store held until one entry drains.
        step();
        for (int i = 0; i < 4; i++) post(32'h300 + 32'(4 * i), 32'hA0 + 32'(i));
        wr_req = 1'b1; wr_addr = 32'h310; wr_data = 32'hA4;
        @(negedge clk);
        chk1("t3_full", full, 1'b1);
        chk1("t3_fifth_held", wr_ack, 1'b0);
        step();
        sram_rdy = 1'b1;
        @(negedge clk);
        chk1("t3_held_in_rdy_cycle", wr_ack, 1'b0);
        step();
        sram_rdy = 1'b0;
        @(negedge clk);
        chk1("t3_fifth_accepted", wr_ack, 1'b1);
        chk1("t3_not_full", full, 1'b0);
        step();
        wr_req = 1'b0;
        drain_all();

        // Forwarding from the youngest matching entry.
        post(32'h200, 32'h11);
        post(32'h204, 32'h22);
        post(32'h200, 32'h33);
        rd_req = 1'b1; rd_addr = 32'h202;
        @(negedge clk);
        chk1("t4_hit_200", rd_hit, 1'b1);
        chk("t4_data_200", rd_data, 32'h33);
        step();
        rd_addr = 32'h204;
        @(negedge clk);
        chk("t4_data_204", rd_data, 32'h22);
        step();
        rd_addr = 32'h208;
        @(negedge clk);
        chk1("t4_miss_208", rd_hit, 1'b0);
        chk("t4_data_miss", rd_data, 32'h0);
        step();
        rd_req = 1'b0;
        drain_all();

        // Random wrap traffic with random SRAM delays and read lookups.
        base = n_done;
        cnt = 0;
        gap = -1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    post(32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)), $urandom);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
            begin
                n = 0;
                while (cnt < 10 && n < 3000) begin
                    step();
                    rd_req  = 1'($urandom_range(0, 1));
                    rd_addr = 32'h400 + 32'($urandom_range(0, 31));
                    if (sram_rdy) sram_rdy = 1'b0;
                    else if (sram_de) begin
                        if (gap < 0) gap = $urandom_range(0, 7);
                        if (gap == 0) begin
                            sram_rdy = 1'b1;
                            gap = -1;
                            cnt++;
                        end else gap--;
                    end
                    n++;
                end
            end
        join
        step();
        sram_rdy = 1'b0;
        rd_req = 1'b0;
        chk("t5_rdy_pulses", cnt, 10);
        chk("t5_sram_writes", n_done - base, 10);
        drain_all();

        // Reset while a write is in flight with three entries queued.
        post(32'h600, 32'h61);
        post(32'h604, 32'h62);
        post(32'h608, 32'h63);
        n = 0;
        while (!sram_de && n < 20) begin
            step();
            n++;
        end
        chk1("t6_de_before_reset", sram_de, 1'b1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk1("t6_de_after_reset", sram_de, 1'b0);
        chk1("t6_empty_after_reset", empty, 1'b1);
        step();
        sram_rdy = 1'b1;
        step();
        sram_rdy = 1'b0;
        @(negedge clk);
        chk1("t6_empty_after_rdy", empty, 1'b1);
        chk1("t6_not_full_after_rdy", full, 1'b0);
        step();
        post(32'h700, 32'h77);
        drain_all();

        @(negedge clk);
        chk("final_scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
